// File: rtl/intt_top.sv
// 16-point inverse NTT over GF(MODULUS): bit-reversed capture, four in-place radix-2 stages, final scale.
// Define INTT_SCALE_EN to multiply the result by N_INV; otherwise the bank is copied to dout unscaled.
module intt_top #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 16,
  parameter int MODULUS    = 17,
  parameter int ROOT_INV   = 6,
  parameter int N_INV      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic [DATA_WIDTH-1:0] din2,
  input  logic [DATA_WIDTH-1:0] din3,
  input  logic [DATA_WIDTH-1:0] din4,
  input  logic [DATA_WIDTH-1:0] din5,
  input  logic [DATA_WIDTH-1:0] din6,
  input  logic [DATA_WIDTH-1:0] din7,
  input  logic [DATA_WIDTH-1:0] din8,
  input  logic [DATA_WIDTH-1:0] din9,
  input  logic [DATA_WIDTH-1:0] din10,
  input  logic [DATA_WIDTH-1:0] din11,
  input  logic [DATA_WIDTH-1:0] din12,
  input  logic [DATA_WIDTH-1:0] din13,
  input  logic [DATA_WIDTH-1:0] din14,
  input  logic [DATA_WIDTH-1:0] din15,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic [DATA_WIDTH-1:0] dout2,
  output logic [DATA_WIDTH-1:0] dout3,
  output logic [DATA_WIDTH-1:0] dout4,
  output logic [DATA_WIDTH-1:0] dout5,
  output logic [DATA_WIDTH-1:0] dout6,
  output logic [DATA_WIDTH-1:0] dout7,
  output logic [DATA_WIDTH-1:0] dout8,
  output logic [DATA_WIDTH-1:0] dout9,
  output logic [DATA_WIDTH-1:0] dout10,
  output logic [DATA_WIDTH-1:0] dout11,
  output logic [DATA_WIDTH-1:0] dout12,
  output logic [DATA_WIDTH-1:0] dout13,
  output logic [DATA_WIDTH-1:0] dout14,
  output logic [DATA_WIDTH-1:0] dout15,
  output logic                  done
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [PW-1:0] Q_W = PW'(MODULUS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STAGE = 2'd1,
    SCALE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_r;
  state_t                next_state_s;
  logic                  load_s;
  logic                  stage_s;
  logic                  scale_s;
  logic [1:0]            cnt_r;
  logic                  done_r;
  logic [DATA_WIDTH-1:0] din_s    [16];
  logic [DATA_WIDTH-1:0] bank_r   [16];
  logic [DATA_WIDTH-1:0] bfly_s   [16];
  logic [DATA_WIDTH-1:0] scaled_s [16];
  logic [DATA_WIDTH-1:0] dout_r   [16];
  logic [3:0]            top_s    [8];
  logic [3:0]            bot_s    [8];
  logic [DATA_WIDTH-1:0] wb_s     [8];

  function automatic logic [DATA_WIDTH-1:0] mulmod(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    logic [PW-1:0] p;
    p = PW'(a) * PW'(b);
    return DATA_WIDTH'(p % Q_W);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] addmod(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    logic [PW-1:0] p;
    p = PW'(a) + PW'(b);
    return DATA_WIDTH'(p % Q_W);
  endfunction

  // b is already reduced below q, so adding q first keeps the difference non-negative
  function automatic logic [DATA_WIDTH-1:0] submod(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    logic [PW-1:0] p;
    p = PW'(a) + Q_W - PW'(b);
    return DATA_WIDTH'(p % Q_W);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] twiddle(input logic [2:0] e);
    logic [DATA_WIDTH-1:0] r;
    r = DATA_WIDTH'(1);
    for (int i = 0; i < 7; i++) begin
      r = (3'(i) < e) ? mulmod(r, DATA_WIDTH'(ROOT_INV)) : r;
    end
    return r;
  endfunction

  function automatic logic [3:0] bitrev4(input logic [3:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

  // Upper-leg index: butterfly number with a zero inserted at bit position c (half-span 2^c)
  function automatic logic [3:0] top_idx(input logic [1:0] c, input logic [2:0] b);
    logic [3:0] r;
    case (c)
      2'd0:    r = {b, 1'b0};
      2'd1:    r = {b[2:1], 1'b0, b[0]};
      2'd2:    r = {b[2], 1'b0, b[1:0]};
      2'd3:    r = {1'b0, b};
      default: r = 4'd0;
    endcase
    return r;
  endfunction

  // Twiddle exponent j*N/(2m): in-group index shifted up by (3-c)
  function automatic logic [2:0] exp_idx(input logic [1:0] c, input logic [2:0] b);
    logic [2:0] r;
    case (c)
      2'd0:    r = 3'd0;
      2'd1:    r = {b[0], 2'b00};
      2'd2:    r = {b[1:0], 1'b0};
      2'd3:    r = b;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  assign din_s[0]  = din0;
  assign din_s[1]  = din1;
  assign din_s[2]  = din2;
  assign din_s[3]  = din3;
  assign din_s[4]  = din4;
  assign din_s[5]  = din5;
  assign din_s[6]  = din6;
  assign din_s[7]  = din7;
  assign din_s[8]  = din8;
  assign din_s[9]  = din9;
  assign din_s[10] = din10;
  assign din_s[11] = din11;
  assign din_s[12] = din12;
  assign din_s[13] = din13;
  assign din_s[14] = din14;
  assign din_s[15] = din15;

  assign dout0  = dout_r[0];
  assign dout1  = dout_r[1];
  assign dout2  = dout_r[2];
  assign dout3  = dout_r[3];
  assign dout4  = dout_r[4];
  assign dout5  = dout_r[5];
  assign dout6  = dout_r[6];
  assign dout7  = dout_r[7];
  assign dout8  = dout_r[8];
  assign dout9  = dout_r[9];
  assign dout10 = dout_r[10];
  assign dout11 = dout_r[11];
  assign dout12 = dout_r[12];
  assign dout13 = dout_r[13];
  assign dout14 = dout_r[14];
  assign dout15 = dout_r[15];
  assign done   = done_r;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = IDLE;
    case (state_r)
      IDLE:    next_state_s = start ? STAGE : IDLE;
      STAGE:   next_state_s = (cnt_r == 2'd3) ? SCALE : STAGE;
      SCALE:   next_state_s = DONE;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Datapath controls decoded from state
  always_comb begin
    load_s  = 1'b0;
    stage_s = 1'b0;
    scale_s = 1'b0;
    case (state_r)
      IDLE:    load_s  = start;
      STAGE:   stage_s = 1'b1;
      SCALE:   scale_s = 1'b1;
      DONE:    scale_s = 1'b0;
      default: scale_s = 1'b0;
    endcase
  end

  // Butterfly leg indices and reduced twiddle products
  always_comb begin
    for (int bf = 0; bf < 8; bf++) begin
      top_s[bf] = top_idx(cnt_r, 3'(bf));
      bot_s[bf] = top_idx(cnt_r, 3'(bf)) | (4'd1 << cnt_r);
      wb_s[bf]  = mulmod(twiddle(exp_idx(cnt_r, 3'(bf))), bank_r[bot_s[bf]]);
    end
  end

  // One full stage of eight butterflies over the bank
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      bfly_s[i] = bank_r[i];
    end
    for (int bf = 0; bf < 8; bf++) begin
      bfly_s[top_s[bf]] = addmod(bank_r[top_s[bf]], wb_s[bf]);
      bfly_s[bot_s[bf]] = submod(bank_r[top_s[bf]], wb_s[bf]);
    end
  end

  // Final scaling by N^-1, or a straight copy when scaling is compiled out
  always_comb begin
    for (int i = 0; i < 16; i++) begin
`ifdef INTT_SCALE_EN
      scaled_s[i] = mulmod(bank_r[i], DATA_WIDTH'(N_INV));
`else
      scaled_s[i] = bank_r[i];
`endif
    end
  end

  // Bank, stage counter, output registers and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= 2'd0;
      done_r <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        bank_r[i] <= '0;
        dout_r[i] <= '0;
      end
    end else begin
      if (load_s) begin
        cnt_r <= 2'd0;
        for (int i = 0; i < 16; i++) begin
          bank_r[bitrev4(4'(i))] <= DATA_WIDTH'(PW'(din_s[i]) % Q_W);
        end
      end else if (stage_s) begin
        cnt_r <= cnt_r + 2'd1;
        for (int i = 0; i < 16; i++) begin
          bank_r[i] <= bfly_s[i];
        end
      end
      if (scale_s) begin
        for (int i = 0; i < 16; i++) begin
          dout_r[i] <= scaled_s[i];
        end
      end
      done_r <= scale_s;
    end
  end

endmodule
